yc_vc_buf: RTL and testbench
============================

Name: yc_vc_buf

Overview:
Multi-virtual-channel ingress buffer for the NoC router port. It is the successor to the single-lane skid/FIFO stage. One write port carries a VC tag. Storage is a per-VC circular FIFO with arbitrary (non-power-of-2) depth and independent per-VC backpressure. A single output port is served by round-robin arbitration with a stable grant.

Parameters:
W, 32, payload width in bits (>=1)
NUM_VC, 4, number of virtual channels (>=1)
DEPTH, 3, entries per VC (>=1, any integer, not restricted to powers of 2)
VCW, $clog2(NUM_VC) min 1, derived localparam: VC tag width
CW, $clog2(DEPTH+1), derived localparam: per-VC count width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  write request
s_vc  in  VCW  target VC of write
s_data  in  W  write payload
s_ready  out  NUM_VC  per-VC space available; bit v = count[v] < DEPTH
m_valid  out  1  output holds valid entry
m_vc  out  VCW  VC of output entry
m_data  out  W  head entry of granted VC
m_ready  in  1  downstream accept
(with YC_VCBUF_LEVEL_EN) level  out  NUM_VC*CW  per-VC occupancy, VC v at [v*CW +: CW]
(with YC_VCBUF_LEVEL_EN) almost_full  out  NUM_VC  bit v = count[v] >= DEPTH-1

Behaviour:
- Reset (rst=1 at an edge) clears all counts, rd/wr indices, grant lock, and RR pointer (to VC 0). Memory contents are not reset.
- After reset: s_ready all 1s, m_valid=0, m_vc=0, level=0, almost_full = (DEPTH==1 ? all 1s : 0).
- Reset mid-transfer discards all stored data. No partial state survives.
- Push: s_valid && s_ready[s_vc]. Data is written at wr_idx[s_vc], then wr_idx advances and count increments.
- s_ready[s_vc]=0 with s_valid=1: no effect. The upstream must hold its request.
- s_ready depends only on registered count. There is no combinational path from m_ready to s_ready.
- s_vc >= NUM_VC: the write is ignored. s_ready bits exist only for legal VCs.
- Indices wrap explicitly: an index at DEPTH-1 goes to 0. There is no modulo-2^n assumption.
- Latency: a push to an empty VC at edge N makes the entry eligible for m_valid in cycle N+1. There is no same-cycle bypass.
- Pop: m_valid && m_ready. The granted VC's rd_idx advances and its count decrements.
- Same-VC push and pop in one cycle: count is unchanged and both indices advance. This is legal whenever count < DEPTH.
- A full VC with a pop in the same cycle still shows s_ready=0 that cycle. The freed slot is visible next cycle.
- Arbitration, with states UNLOCKED and LOCKED:
  - UNLOCKED: the grant is the first non-empty VC searching from rr_ptr upward with wrap. m_valid = any VC non-empty.
  - Stall (m_valid && !m_ready) moves to LOCKED, holding the grant. m_vc and m_data must stay stable until accepted.
  - A locked VC cannot become empty, because only pops remove entries.
  - On any pop: rr_ptr = granted VC + 1 (wrapping at NUM_VC), and the state returns to UNLOCKED.
  - NUM_VC=1: the arbiter degenerates to a pass-through.
- Fairness: with all VCs continuously non-empty and m_ready=1, grants rotate 0,1,2,...,NUM_VC-1,0.

Optional Feature:
YC_VCBUF_LEVEL_EN:
- Defined: the level and almost_full ports exist and are driven from the registered counts. They are used by the upstream credit/VC allocator.
- Undefined: neither port exists. Internal behaviour is otherwise identical.

Decomposition:
- Package yc_noc_pkg holds:
  - function yc_idx_w(n), returning max(1, $clog2(n));
  - function yc_wrap_inc(idx, n), the explicit-wrap increment;
  - typedef enum {ARB_UNLOCKED, ARB_LOCKED} yc_arb_st_e.
- One sub-module, yc_rr_arb:
  - parameter N;
  - inputs req[N], lock, advance;
  - outputs gnt_idx and gnt_valid;
  - owns rr_ptr and the lock state.
- Storage is a flat array of NUM_VC*DEPTH entries in yc_vc_buf.

Test Plan:
- NUM_VC=4, DEPTH=3: 3 pushes to VC2 (0xA0,0xA1,0xA2), m_ready=0 -> s_ready=4'b1011. A 4th push is ignored. Then m_ready=1 -> output 0xA0,0xA1,0xA2 on m_vc=2, in order.
- Fill VC0..VC3 with 2 entries each, then m_ready=1 constant -> m_vc sequence 0,1,2,3,0,1,2,3, then m_valid=0.
- Grant stability: VC1 is head, m_ready=0 for 5 cycles while VC0 receives pushes -> m_vc=1 and m_data unchanged throughout. The first pop takes VC1, the next grant is VC0.
- DEPTH=3 wrap: 10 interleaved push/pop on VC3 at count 1 -> data order preserved across the index wrap and count stays 1. With LEVEL_EN, level[3]=1 throughout.
- Simultaneous events: VC0 full, pop VC0 and push VC0 in the same cycle -> push not accepted (s_ready[0]=0). Next cycle s_ready[0]=1 and level[0]=2.
- Reset mid-operation: rst=1 for one cycle with 5 entries buffered -> next cycle m_valid=0, s_ready=4'b1111, level all 0. Stale data is never emitted.

Source files
------------

// File: rtl/yc_noc_pkg.sv
// Shared NoC helpers: index-width sizing, explicit-wrap increment, arbiter state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package yc_noc_pkg;

    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } yc_arb_st_e;

    function automatic int yc_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Depths need not be powers of two, so the wrap is an explicit compare.
    function automatic logic [31:0] yc_wrap_inc(input logic [31:0] idx, input int n);
        return (idx >= 32'(n - 1)) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/yc_rr_arb.sv
// Round-robin arbiter with a grant lock; owns the rr pointer and the lock state.
// Latency: grant is combinational from req while unlocked, registered while locked.
// Backpressure: lock freezes the grant until advance; advance moves rr_ptr past the winner.
module yc_rr_arb
    import yc_noc_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = yc_idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          lock,
    input  logic          advance,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    yc_arb_st_e    st;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] held_idx;
    logic [IW-1:0] srch_idx;
    logic          srch_hit;

    // Scan from the farthest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        srch_idx = '0;
        srch_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            int c;
            c = int'(rr_ptr) + i;
            if (c >= N) c = c - N;
            if (req[IW'(c)]) begin
                srch_idx = IW'(c);
                srch_hit = 1'b1;
            end
        end
    end

    assign gnt_idx   = (st == ARB_LOCKED) ? held_idx : srch_idx;
    assign gnt_valid = (st == ARB_LOCKED) || srch_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= ARB_UNLOCKED;
            rr_ptr   <= '0;
            held_idx <= '0;
        end else if (advance) begin
            rr_ptr <= IW'(yc_wrap_inc(32'(gnt_idx), N));
            st     <= ARB_UNLOCKED;
        end else if (lock) begin
            st       <= ARB_LOCKED;
            held_idx <= gnt_idx;
        end
    end

endmodule

// File: rtl/yc_vc_buf.sv
// Multi-VC ingress buffer: per-VC circular FIFOs in one flat array, RR-arbitrated output.
// Latency: 1 cycle push-to-m_valid, no bypass. Backpressure: per-VC s_ready from registered count;
// a stalled output holds m_vc/m_data. Optional ports level/almost_full under YC_VCBUF_LEVEL_EN.
module yc_vc_buf
    import yc_noc_pkg::*;
#(
    parameter  int W      = 32,
    parameter  int NUM_VC = 4,
    parameter  int DEPTH  = 3,
    localparam int VCW    = yc_idx_w(NUM_VC),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [VCW-1:0]       s_vc,
    input  logic [W-1:0]         s_data,
    output logic [NUM_VC-1:0]    s_ready,
    output logic                 m_valid,
    output logic [VCW-1:0]       m_vc,
    output logic [W-1:0]         m_data,
    input  logic                 m_ready
`ifdef YC_VCBUF_LEVEL_EN
    ,
    output logic [NUM_VC*CW-1:0] level,
    output logic [NUM_VC-1:0]    almost_full
`endif
);

    localparam int IW = yc_idx_w(DEPTH);
    localparam int AW = yc_idx_w(NUM_VC * DEPTH);

    logic [W-1:0]        mem    [NUM_VC*DEPTH];
    logic [CW-1:0]       cnt    [NUM_VC];
    logic [IW-1:0]       wr_idx [NUM_VC];
    logic [IW-1:0]       rd_idx [NUM_VC];
    logic [NUM_VC-1:0]   nonempty;
    logic [NUM_VC-1:0]   push_v;
    logic [NUM_VC-1:0]   pop_v;
    logic [VCW-1:0]      gnt;
    logic                gnt_vld;
    logic                pop;
    logic [AW-1:0]       rd_addr;

    assign pop = gnt_vld && m_ready;

    // Out-of-range s_vc matches no v, so such writes fall through untouched.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            s_ready[v]  = int'(cnt[v]) < DEPTH;
            nonempty[v] = cnt[v] != '0;
            push_v[v]   = s_valid && (int'(s_vc) == v) && (int'(cnt[v]) < DEPTH);
            pop_v[v]    = pop && (int'(gnt) == v);
        end
    end

    yc_rr_arb #(.N(NUM_VC)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (nonempty),
        .lock      (gnt_vld && !m_ready),
        .advance   (pop),
        .gnt_idx   (gnt),
        .gnt_valid (gnt_vld)
    );

    assign rd_addr = AW'(int'(gnt) * DEPTH + int'(rd_idx[gnt]));
    assign m_valid = gnt_vld;
    assign m_vc    = gnt;
    assign m_data  = mem[rd_addr];

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push_v[v]) mem[AW'(v * DEPTH + int'(wr_idx[v]))] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                cnt[v]    <= '0;
                wr_idx[v] <= '0;
                rd_idx[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_v[v]) wr_idx[v] <= IW'(yc_wrap_inc(32'(wr_idx[v]), DEPTH));
                if (pop_v[v])  rd_idx[v] <= IW'(yc_wrap_inc(32'(rd_idx[v]), DEPTH));
                case ({push_v[v], pop_v[v]})
                    2'b10:   cnt[v] <= cnt[v] + CW'(1);
                    2'b01:   cnt[v] <= cnt[v] - CW'(1);
                    default: cnt[v] <= cnt[v];
                endcase
            end
        end
    end

`ifdef YC_VCBUF_LEVEL_EN
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            level[v*CW +: CW] = cnt[v];
            almost_full[v]    = int'(cnt[v]) >= DEPTH - 1;
        end
    end
`endif

endmodule

// File: tb/tb_yc_vc_buf.sv
// Bench for yc_vc_buf: directed scenarios plus randomized traffic against a queue-based model.
// Outputs are sampled 1-2 time units after the rising edge; inputs change 1 unit after it.
module tb_yc_vc_buf;

    localparam int W  = 32;
    localparam int NV = 4;
    localparam int D  = 3;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [1:0]    s_vc;
    logic [W-1:0]  s_data;
    logic [NV-1:0] s_ready;
    logic          m_valid;
    logic [1:0]    m_vc;
    logic [W-1:0]  m_data;
    logic          m_ready;
`ifdef YC_VCBUF_LEVEL_EN
    logic [NV*CW-1:0] level;
    logic [NV-1:0]    almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: one queue per VC, the rotation origin, and the VC whose
    // offered head was refused last cycle (-1 when none).
    logic [W-1:0] q [NV][$];
    int rr   = 0;
    int held = -1;

    always #5 clk = ~clk;

    yc_vc_buf #(.W(W), .NUM_VC(NV), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_vc        (s_vc),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_vc        (m_vc),
        .m_data      (m_data),
        .m_ready     (m_ready)
`ifdef YC_VCBUF_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_gnt();
        if (held >= 0) return held;
        for (int i = 0; i < NV; i++) begin
            if (q[(rr + i) % NV].size() > 0) return (rr + i) % NV;
        end
        return -1;
    endfunction

    // One clock: check outputs against the model, apply this cycle's inputs to the model, clock.
    task automatic cyc();
        int g;
        bit acc;
        logic [NV-1:0] er;
        #1;
        g = exp_gnt();
        if (chk_en) begin
            for (int v = 0; v < NV; v++) er[v] = q[v].size() < D;
            chk("s_ready", 64'(s_ready), 64'(er));
            chk("m_valid", 64'(m_valid), 64'(g >= 0));
            if (g >= 0) begin
                chk("m_vc", 64'(m_vc), 64'(g));
                chk("m_data", 64'(m_data), 64'(q[g][0]));
            end
`ifdef YC_VCBUF_LEVEL_EN
            for (int v = 0; v < NV; v++) begin
                chk("level", 64'(level[v*CW +: CW]), 64'(q[v].size()));
                chk("almost_full", 64'(almost_full[v]), 64'(q[v].size() >= D - 1));
            end
`endif
        end
        if (rst) begin
            for (int v = 0; v < NV; v++) q[v].delete();
            rr   = 0;
            held = -1;
        end else begin
            acc = s_valid && (q[int'(s_vc)].size() < D);
            if (g >= 0) begin
                if (m_ready) begin
                    void'(q[g].pop_front());
                    rr   = (g + 1) % NV;
                    held = -1;
                end else begin
                    held = g;
                end
            end
            if (acc) q[int'(s_vc)].push_back(s_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int vc, input logic [W-1:0] d, input bit rdy);
        s_valid = v;
        s_vc    = 2'(vc);
        s_data  = d;
        m_ready = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, '0, 0);
        cyc();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'hF);
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_m_vc", 64'(m_vc), 64'h0);
`ifdef YC_VCBUF_LEVEL_EN
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_almost_full", 64'(almost_full), 64'h0);
`endif

        // Fill VC2, overflow attempt, then drain in order
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 32'hA0 + 32'(i), 0);
            cyc();
        end
        chk("full_vc2_s_ready", 64'(s_ready), 64'hB);
        drive(1, 2, 32'hA3, 0);
        cyc();
        chk("full_vc2_after_extra", 64'(s_ready), 64'hB);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1);
            chk("vc2_m_vc", 64'(m_vc), 64'h2);
            chk("vc2_m_data", 64'(m_data), 64'(32'hA0 + 32'(i)));
            cyc();
        end
        chk("vc2_drained", 64'(m_valid), 64'h0);

        // Two entries in every VC, then free-running drain must rotate
        for (int i = 0; i < 8; i++) begin
            drive(1, i / 2, 32'hB0 + 32'(i), 0);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, '0, 1);
            chk("rr_valid", 64'(m_valid), 64'h1);
            chk("rr_seq", 64'(m_vc), 64'(k % NV));
            cyc();
        end
        chk("rr_drained", 64'(m_valid), 64'h0);

        // Grant stability while a lower VC fills
        drive(1, 1, 32'h11, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'hC0 + 32'(i), 0);
            chk("stall_m_vc", 64'(m_vc), 64'h1);
            chk("stall_m_data", 64'(m_data), 64'h11);
            cyc();
        end
        drive(0, 0, '0, 1);
        chk("stall_pop_vc", 64'(m_vc), 64'h1);
        cyc();
        chk("after_stall_vc", 64'(m_vc), 64'h0);
        chk("after_stall_data", 64'(m_data), 64'hC0);
        for (int i = 0; i < 3; i++) cyc();
        chk("stall_drained", 64'(m_valid), 64'h0);

        // Index wrap with simultaneous push/pop on VC3 at count 1
        drive(1, 3, 32'h30, 0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(1, 3, 32'h31 + 32'(i), 1);
            chk("wrap_m_vc", 64'(m_vc), 64'h3);
            chk("wrap_m_data", 64'(m_data), 64'(32'h30 + 32'(i)));
`ifdef YC_VCBUF_LEVEL_EN
            chk("wrap_level3", 64'(level[3*CW +: CW]), 64'h1);
`endif
            cyc();
        end
        drive(0, 0, '0, 1);
        cyc();
        chk("wrap_drained", 64'(m_valid), 64'h0);

        // Full VC0: pop and push in the same cycle, push refused
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'hE0 + 32'(i), 0);
            cyc();
        end
        drive(1, 0, 32'hE3, 1);
        chk("full_pop_s_ready0", 64'(s_ready[0]), 64'h0);
        cyc();
        chk("freed_s_ready0", 64'(s_ready[0]), 64'h1);
`ifdef YC_VCBUF_LEVEL_EN
        chk("freed_level0", 64'(level[0 +: CW]), 64'h2);
`endif
        drive(0, 0, '0, 1);
        cyc();
        cyc();
        chk("full_drained", 64'(m_valid), 64'h0);

        // Reset with five entries buffered
        for (int i = 0; i < 5; i++) begin
            drive(1, i % NV, 32'hF0 + 32'(i), 0);
            cyc();
        end
        rst = 1'b1;
        drive(0, 0, '0, 0);
        cyc();
        rst = 1'b0;
        chk("midrst_m_valid", 64'(m_valid), 64'h0);
        chk("midrst_s_ready", 64'(s_ready), 64'hF);
`ifdef YC_VCBUF_LEVEL_EN
        chk("midrst_level", 64'(level), 64'h0);
`endif
        drive(0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("midrst_no_stale", 64'(m_valid), 64'h0);
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 6, int'($urandom_range(0, NV - 1)),
                  $urandom, $urandom_range(0, 1) == 1);
            cyc();
        end
        rst = 1'b0;
        drive(0, 0, '0, 1);
        for (int i = 0; i < 4 * D + 2; i++) cyc();
        chk("final_empty", 64'(m_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
